// File: rtl/sa_child_resp_merge.sv
// Round-robin merge of N_CHILD request channels into one registered output slot; 1-cycle accept-to-output latency.
// Backpressure: while the slot is full and out_ready is low, every in_ready bit is held at zero.
module sa_child_resp_merge #(
   parameter int DATA_W  = 32,
   parameter int N_CHILD = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_CHILD-1:0]        in_valid,
   input  logic [N_CHILD*DATA_W-1:0] in_data,
   output logic [N_CHILD-1:0]        in_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [2:0]                out_src,
   input  logic                      out_ready,
   output logic [15:0]               xfer_count
);

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [2:0]        r_out_src;
   logic [15:0]       r_xfer_count;
   logic [2:0]        r_rr_ptr;

   logic              w_load_en;
   logic              w_found;
   logic [2:0]        w_grant;
   logic [2:0]        w_rr_next;
   logic [DATA_W-1:0] w_grant_dat;

   assign w_load_en = !r_out_valid || out_ready;

   // Search upward from r_rr_ptr, wrapping modulo N_CHILD; first requester wins.
   always_comb begin
      int idx;
      w_found = 1'b0;
      w_grant = 3'd0;
      idx     = 0;
      for (int k = 0; k < N_CHILD; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= N_CHILD) idx = idx - N_CHILD;
         if (!w_found && in_valid[idx]) begin
            w_found = 1'b1;
            w_grant = 3'(idx);
         end
      end
   end

   assign w_rr_next   = (w_grant == 3'(N_CHILD-1)) ? 3'd0 : w_grant + 3'd1;
   assign w_grant_dat = in_data[w_grant*DATA_W +: DATA_W];

   // rst_n gate keeps in_ready low for the whole time reset is held.
   always_comb begin
      in_ready = '0;
      if (rst_n && w_load_en && w_found) in_ready[w_grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_src    <= 3'd0;
         r_rr_ptr     <= 3'd0;
         r_xfer_count <= 16'd0;
      end else begin
         if (w_load_en) begin
            r_out_valid <= w_found;
            if (w_found) begin
               r_out_data <= w_grant_dat;
               r_out_src  <= w_grant;
               r_rr_ptr   <= w_rr_next;
            end
         end
         if (r_out_valid && out_ready) r_xfer_count <= r_xfer_count + 16'd1;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_src    = r_out_src;
   assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_sa_child_resp_merge.sv
// Directed vector bench for sa_child_resp_merge: per-cycle table plus reset and counter-wrap sequences.
module tb_sa_child_resp_merge;

   localparam int DW = 32;
   localparam int NC = 5;

   logic             clk;
   logic             rst_n;
   logic [NC-1:0]    in_valid;
   logic [NC*DW-1:0] in_data;
   logic [NC-1:0]    in_ready;
   logic             out_valid;
   logic [DW-1:0]    out_data;
   logic [2:0]       out_src;
   logic             out_ready;
   logic [15:0]      xfer_count;

   int n_checks = 0;
   int n_errors = 0;

   sa_child_resp_merge #(.DATA_W(DW), .N_CHILD(NC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_src    (out_src),
      .out_ready  (out_ready),
      .xfer_count (xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NC-1:0] iv;
      logic          ordy;
      logic [NC-1:0] exp_rdy;
      logic          exp_ov;
      logic [2:0]    exp_src;
      logic [15:0]   exp_cnt;
   } vec_t;

   vec_t          vecs[25];
   logic [DW-1:0] child_dat[NC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic setv(input int i, input logic [NC-1:0] iv, input logic ordy,
                       input logic [NC-1:0] rdy, input logic ov, input logic [2:0] src,
                       input logic [15:0] cnt);
      vecs[i].iv = iv; vecs[i].ordy = ordy; vecs[i].exp_rdy = rdy;
      vecs[i].exp_ov = ov; vecs[i].exp_src = src; vecs[i].exp_cnt = cnt;
   endtask

   initial begin
      child_dat[0] = 32'hA0A0_0000;
      child_dat[1] = 32'hB1B1_1111;
      child_dat[2] = 32'hDEAD_BEEF;
      child_dat[3] = 32'hC3C3_3333;
      child_dat[4] = 32'hE4E4_4444;
      for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = child_dat[i];

      // Fairness: all children requesting, out_src walks 0..4,0 and count reaches 6.
      setv(0,  5'h1F, 1, 5'h01, 0, 0, 0);
      setv(1,  5'h1F, 1, 5'h02, 1, 0, 0);
      setv(2,  5'h1F, 1, 5'h04, 1, 1, 1);
      setv(3,  5'h1F, 1, 5'h08, 1, 2, 2);
      setv(4,  5'h1F, 1, 5'h10, 1, 3, 3);
      setv(5,  5'h1F, 1, 5'h01, 1, 4, 4);
      setv(6,  5'h00, 1, 5'h00, 1, 0, 5);
      setv(7,  5'h00, 1, 5'h00, 0, 0, 6);
      // Wrap: grant child 3 (rr -> 4), then children 1 and 4 -> 4 first, then 1.
      setv(8,  5'h08, 1, 5'h08, 0, 0, 6);
      setv(9,  5'h12, 1, 5'h10, 1, 3, 6);
      setv(10, 5'h02, 1, 5'h02, 1, 4, 7);
      setv(11, 5'h00, 1, 5'h00, 1, 1, 8);
      // Backpressure: child 2 beat held for 3 cycles, completes when out_ready rises.
      setv(12, 5'h04, 0, 5'h04, 0, 1, 9);
      setv(13, 5'h00, 0, 5'h00, 1, 2, 9);
      setv(14, 5'h1F, 0, 5'h00, 1, 2, 9);
      setv(15, 5'h1F, 0, 5'h00, 1, 2, 9);
      setv(16, 5'h1F, 1, 5'h08, 1, 2, 9);
      setv(17, 5'h00, 1, 5'h00, 1, 3, 10);
      setv(18, 5'h00, 1, 5'h00, 0, 3, 11);
      // Throughput: child 0 on four consecutive cycles, out_valid stays high.
      setv(19, 5'h01, 1, 5'h01, 0, 3, 11);
      setv(20, 5'h01, 1, 5'h01, 1, 0, 11);
      setv(21, 5'h01, 1, 5'h01, 1, 0, 12);
      setv(22, 5'h01, 1, 5'h01, 1, 0, 13);
      setv(23, 5'h00, 1, 5'h00, 1, 0, 14);
      setv(24, 5'h00, 1, 5'h00, 0, 0, 15);

      rst_n     = 1'b0;
      in_valid  = 5'h1F;
      out_ready = 1'b1;
      #12;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", out_data, 32'd0);
      chk("reset_out_src", 32'(out_src), 32'd0);
      chk("reset_xfer_count", 32'(xfer_count), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 25; i++) begin
         if (i > 0) @(negedge clk);
         in_valid  = vecs[i].iv;
         out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         chk($sformatf("v%0d_out_src", i), 32'(out_src), 32'(vecs[i].exp_src));
         chk($sformatf("v%0d_xfer_count", i), 32'(xfer_count), 32'(vecs[i].exp_cnt));
         if (vecs[i].exp_ov)
            chk($sformatf("v%0d_out_data", i), out_data, child_dat[vecs[i].exp_src]);
      end

      // Mid-cycle reset with a held beat: outputs clear before the next edge.
      @(negedge clk);
      in_valid  = 5'h04;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 5'h1F;
      #1;
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_xfer_count", 32'(xfer_count), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_out_data", out_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_first_grant", 32'(in_ready), 32'h01);
      @(negedge clk);
      #1;
      chk("post_rst_out_src", 32'(out_src), 32'd0);
      chk("post_rst_out_valid", 32'(out_valid), 32'd1);

      // Protocol violation: child 1 withdraws while stalled; child 3 is next granted cleanly.
      in_valid = 5'h02;
      @(negedge clk);
      in_valid  = 5'h08;
      out_ready = 1'b1;
      #1;
      chk("violation_in_ready", 32'(in_ready), 32'h08);
      @(negedge clk);
      #1;
      chk("violation_out_src", 32'(out_src), 32'd3);
      chk("violation_out_data", out_data, child_dat[3]);

      // Counter wrap: fresh reset, stream child 0 until the count reads 0xFFFF, then one more.
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = 5'h01;
      out_ready = 1'b1;
      begin
         int cyc;
         cyc = 0;
         while (xfer_count != 16'hFFFF && cyc < 70000) begin
            @(negedge clk);
            cyc++;
         end
         chk("wrap_reach_ffff", 32'(xfer_count), 32'h0000_FFFF);
         chk("wrap_cycles", 32'(cyc), 32'd65536);
      end
      in_valid = 5'h00;
      #1;
      chk("wrap_last_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      #1;
      chk("wrap_to_zero", 32'(xfer_count), 32'd0);
      chk("wrap_drain_valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sa_child_resp_merge.md
SA_CHILD_RESP_MERGE -- requirements
Module: sa_child_resp_merge

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning the payload width per child channel.
REQ-002 The module SHALL have parameter N_CHILD, default 5, meaning the number of child channels (legal 2..8).
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, N_CHILD bits: per-child request valid.
REQ-006 The module SHALL have port in_data, input, N_CHILD*DATA_W bits: per-child payload; child i occupies bits [i*DATA_W +: DATA_W].
REQ-007 The module SHALL have port in_ready, output, N_CHILD bits: per-child accept.
REQ-008 The module SHALL have port out_valid, output, 1 bit: merged response valid.
REQ-009 The module SHALL have port out_data, output, DATA_W bits: merged payload.
REQ-010 The module SHALL have port out_src, output, 3 bits: index of the child that produced out_data.
REQ-011 The module SHALL have port out_ready, input, 1 bit: parent accept.
REQ-012 The module SHALL have port xfer_count, output, 16 bits: count of completed output handshakes.

Function
REQ-013 A transfer SHALL occur on a channel only in a cycle where its valid and ready are both high at the clock edge.
REQ-014 The output stage SHALL be a single register slot (out_valid/out_data/out_src) with load_en = !out_valid || out_ready.
REQ-015 When load_en is high, exactly one requesting child SHALL be granted by round-robin: the first i with in_valid[i] high, searching from rr_ptr upward and wrapping modulo N_CHILD.
REQ-016 in_ready[i] SHALL be high only for the granted child and only when load_en is high; at most one bit of in_ready SHALL be high in any cycle.
REQ-017 in_ready SHALL depend combinationally on in_valid, rr_ptr and load_en, with no path from in_data.
REQ-018 On a grant, the next edge SHALL load out_data with the granted payload and out_src with the granted index, and SHALL set out_valid to 1; latency from input acceptance to out_valid is 1 cycle.
REQ-019 On a grant, rr_ptr SHALL become (grant+1) mod N_CHILD; otherwise rr_ptr SHALL hold.
REQ-020 When load_en is high and no in_valid bit is set, out_valid SHALL become 0 at the next edge if out_ready was high; out_data and out_src SHALL hold their values.
REQ-021 Simultaneous output pop and input grant SHALL sustain full throughput: one transfer per cycle with out_valid remaining high.
REQ-022 While out_valid is high and out_ready is low, out_valid, out_data and out_src SHALL remain stable and in_ready SHALL be all zero.
REQ-023 xfer_count SHALL increment by 1 on each out_valid && out_ready edge and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 Children SHALL hold in_valid and in_data stable until they are accepted; a child deasserting in_valid before acceptance SHALL be a protocol violation, and the module SHALL then grant the next requester without corrupting its state.

Reset
REQ-025 Asserting rst_n low SHALL immediately force out_valid=0, out_data=0, out_src=0, xfer_count=0, rr_ptr=0 and in_ready=0, regardless of clk.
REQ-026 Reset asserted mid-transfer SHALL discard any held output beat; the first grant after release SHALL start its search at child 0.
REQ-027 Deassertion of rst_n SHALL be synchronised to clk by the integrator; the first grant SHALL occur no earlier than the first rising edge after release.

Verification
REQ-028 Reset check: drive rst_n low mid-cycle with out_valid=1 -> out_valid, xfer_count and in_ready all read 0 before the next clock edge.
REQ-029 Fairness check: hold all 5 in_valid high with out_ready=1 -> out_src sequence is 0,1,2,3,4,0 on consecutive cycles and xfer_count reaches 6.
REQ-030 Wrap check: set rr_ptr=4 (grant child 3 first), then present only child 1 and child 4 -> child 4 is granted, then child 1.
REQ-031 Backpressure check: hold out_ready=0 for 3 cycles with child 2 at data 0xDEADBEEF -> out_data stays 0xDEADBEEF with out_src=2, in_ready stays 0, and the beat completes on the cycle out_ready rises.
REQ-032 Counter wrap check: preload via 65535 handshakes, then perform one more handshake -> xfer_count reads 0x0000.
REQ-033 Throughput check: with out_ready=1, issue child 0 requests on cycles 1..4 -> out_valid stays high on cycles 2..5 and in_ready[0] stays high on cycles 1..4.
